sfx_playback_scheduler: RTL
===========================

// Module: sfx_playback_scheduler
// PURPOSE
//  Sequences a single read-only audio sample BRAM shared by N_CLIPS sound effects.
//  Each clip is a contiguous region (CLIP_BASE/CLIP_LEN). Game-logic trigger requests are
//  latched and arbitrated at fixed priority (index 0 highest), with optional preemption.
//  Steps the BRAM address at the 12 kHz sample tick and emits signed 8-bit samples to the
//  audio output path.
// PARAMETERS
//  N_CLIPS    4                    number of clips/requesters
//  ADDR_W     16                   BRAM address width (65536-deep, 8-bit RAM)
//  ID_W       2                    width of active_id_out, >= clog2(N_CLIPS)
//  CLIP_BASE  {16'd0,16'd19200,16'd32000,16'd48000}  packed, entry i = [i*ADDR_W +: ADDR_W]; first BRAM address of clip i
//  CLIP_LEN   {16'd19200,16'd12800,16'd16000,16'd8000} packed, same layout; sample count of clip i, every entry >= 1
//  PREEMPT    1                    1: pending higher-priority clip cuts active clip at next tick
//  RD_LAT     2                    BRAM read latency in clk_in cycles (output register enabled)
// PORTS
//  clk_in         in   1        system clock; the only clock
//  rst_in         in   1        reset, asynchronous, active-high
//  trigger_in     in   N_CLIPS  bit i high in any cycle requests clip i
//  signal_12khz   in   1        1-cycle sample tick; ticks are >= RD_LAT+2 cycles apart
//  bram_addr_out  out  ADDR_W   read address to sample BRAM (registered)
//  bram_data_in   in   8        BRAM douta
//  audio_out      out  8 (signed) current sample; 0 when silent
//  busy_out       out  1        1 while in PLAY
//  active_id_out  out  ID_W     index of clip being played (holds last value when idle)
//  done_out       out  1        1-cycle pulse when a clip plays to completion
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; pending=0; offset=0; bram_addr_out=0;
//   audio_out=0; busy_out=0; active_id_out=0; done_out=0; capture pipe cleared.
//  Pending: pending[i] <= 1 when trigger_in[i]=1. Cleared in the cycle clip i is granted
//   (grant wins over a same-cycle trigger). trigger for clip currently active is dropped.
//  Grant = lowest-index set pending bit. Evaluated in IDLE every cycle; in PLAY only on
//   tick cycles, only for index < active_id_out, only if PREEMPT=1.
//  FSM IDLE: if any pending -> grant i: active_id_out<=i, offset<=0,
//   bram_addr_out<=CLIP_BASE[i], busy_out<=1, state PLAY (1 cycle grant latency).
//  FSM PLAY, on signal_12khz:
//   - push capture token into RD_LAT+1 deep pipe (samples data of current bram_addr_out)
//   - if preempt grant j: reload as above for j; old clip abandoned, no done_out, not re-queued
//   - elif offset==CLIP_LEN[id]-1: state IDLE, busy_out<=0, done_out<=1 for 1 cycle, offset<=0
//   - else offset<=offset+1, bram_addr_out<=CLIP_BASE[id]+offset+1 (ADDR_W wrap, no saturation)
//   PLAY without tick: hold all.
//  Capture: token emerging from pipe -> audio_out<=bram_data_in. Tick-to-audio_out latency
//   RD_LAT+1 cycles (3 at default); audio_out holds between ticks.
//  IDLE tick: audio_out<=0 immediately (last token always drained before next tick).
//  Back-to-back: done in tick cycle t, pending clip granted at t+1, its first sample issued
//   on the following tick -> no extra silent tick inserted beyond that.
//  Simultaneous triggers: lowest index granted, others stay pending and play in index order.
//  Reset mid-clip: all state cleared immediately, audio_out=0, no done_out.
// TESTING
//  1 trigger_in=4'b0001 one cycle -> busy_out next cycle, addr 0..19199 one step/tick,
//    done_out single pulse after tick 19200, audio_out=mem[k] RD_LAT+1 cycles after tick k.
//  2 trigger_in=4'b1010 same cycle -> clip1 plays fully, then clip3 granted next cycle,
//    active_id_out 1 then 3, two done_out pulses.
//  3 PREEMPT=1: clip2 at offset 100, trigger clip0 -> next tick addr=0, active_id_out=0,
//    no done_out for clip2, clip2 not replayed; PREEMPT=0 -> clip0 waits for clip2 done.
//  4 trigger clip3 while clip3 active -> ignored, one done_out only; trigger same cycle as
//    grant of that clip -> no second playback.
//  5 assert rst_in mid-PLAY between clock edges -> outputs reset asynchronously, no done_out,
//    pending lost; release -> IDLE, audio_out=0.
//  6 ticks in IDLE -> audio_out=0, bram_addr_out stable; CLIP_LEN=1 clip -> one sample, done.

Source files
------------

// File: rtl/sfx_playback_scheduler.sv
// Single-BRAM sound-effect sequencer: latches triggers, arbitrates by fixed priority,
// steps the clip address on each sample tick and captures the returned sample.
module sfx_playback_scheduler #(
    parameter int unsigned N_CLIPS = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned ID_W    = 2,
    parameter logic [N_CLIPS*ADDR_W-1:0] CLIP_BASE = {16'd48000, 16'd32000, 16'd19200, 16'd0},
    parameter logic [N_CLIPS*ADDR_W-1:0] CLIP_LEN  = {16'd8000, 16'd16000, 16'd12800, 16'd19200},
    parameter bit          PREEMPT = 1'b1,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [N_CLIPS-1:0]  trigger_in,
    input  logic                signal_12khz,
    output logic [ADDR_W-1:0]   bram_addr_out,
    input  logic [7:0]          bram_data_in,
    output logic signed [7:0]   audio_out,
    output logic                busy_out,
    output logic [ID_W-1:0]     active_id_out,
    output logic                done_out
);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t              state, state_nx;
    logic [N_CLIPS-1:0]  pending, pending_nx;
    logic [N_CLIPS-1:0]  trig_eff;
    logic [ADDR_W-1:0]   offset, offset_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic signed [7:0]   audio_nx;
    logic                busy_nx;
    logic [ID_W-1:0]     id_nx;
    logic                done_nx;
    logic                push;
    logic [RD_LAT-1:0]   pipe;
    logic [RD_LAT:0]     pipe_shift;
    logic                grant_valid;
    logic [ID_W-1:0]     grant_id;

    function automatic logic [ADDR_W-1:0] base_of(input logic [ID_W-1:0] id);
        logic [ADDR_W-1:0] b;
        b = '0;
        for (int i = 0; i < int'(N_CLIPS); i++)
            if (ID_W'(i) == id) b = CLIP_BASE[i*ADDR_W +: ADDR_W];
        return b;
    endfunction

    function automatic logic [ADDR_W-1:0] len_of(input logic [ID_W-1:0] id);
        logic [ADDR_W-1:0] l;
        l = '0;
        for (int i = 0; i < int'(N_CLIPS); i++)
            if (ID_W'(i) == id) l = CLIP_LEN[i*ADDR_W +: ADDR_W];
        return l;
    endfunction

    // Lowest-index pending clip; while playing only higher-priority clips on a tick may cut in
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int i = 0; i < int'(N_CLIPS); i++) begin
            if (!grant_valid && pending[i] &&
                (state == IDLE ||
                 (PREEMPT && signal_12khz && ID_W'(i) < active_id_out))) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(i);
            end
        end
    end

    assign pipe_shift = {pipe, push};

    always_comb begin
        state_nx = state;
        offset_nx = offset;
        addr_nx  = bram_addr_out;
        audio_nx = audio_out;
        busy_nx  = busy_out;
        id_nx    = active_id_out;
        done_nx  = 1'b0;
        push     = 1'b0;
        trig_eff = trigger_in;

        if (state == PLAY) trig_eff[active_id_out] = 1'b0;
        pending_nx = pending | trig_eff;
        if (grant_valid) pending_nx[grant_id] = 1'b0;

        case (state)
            IDLE: begin
                if (signal_12khz) audio_nx = '0;
                if (grant_valid) begin
                    state_nx  = PLAY;
                    id_nx     = grant_id;
                    offset_nx = '0;
                    addr_nx   = base_of(grant_id);
                    busy_nx   = 1'b1;
                end
            end
            PLAY: begin
                if (signal_12khz) begin
                    push = 1'b1;
                    if (grant_valid) begin
                        id_nx     = grant_id;
                        offset_nx = '0;
                        addr_nx   = base_of(grant_id);
                    end else if (offset == len_of(active_id_out) - ADDR_W'(1)) begin
                        state_nx  = IDLE;
                        busy_nx   = 1'b0;
                        done_nx   = 1'b1;
                        offset_nx = '0;
                    end else begin
                        offset_nx = offset + ADDR_W'(1);
                        addr_nx   = base_of(active_id_out) + offset + ADDR_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Token reaching the end of the pipe marks the cycle douta holds the ticked address
        if (pipe[RD_LAT-1]) audio_nx = signed'(bram_data_in);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= IDLE;
            pending       <= '0;
            offset        <= '0;
            bram_addr_out <= '0;
            audio_out     <= '0;
            busy_out      <= 1'b0;
            active_id_out <= '0;
            done_out      <= 1'b0;
            pipe          <= '0;
        end else begin
            state         <= state_nx;
            pending       <= pending_nx;
            offset        <= offset_nx;
            bram_addr_out <= addr_nx;
            audio_out     <= audio_nx;
            busy_out      <= busy_nx;
            active_id_out <= id_nx;
            done_out      <= done_nx;
            pipe          <= pipe_shift[RD_LAT-1:0];
        end
    end

endmodule
